fp16_divider: RTL
=================

FP16_DIVIDER -- requirements
Module: fp16_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, and SHALL expose exactly the ports in REQ-002..REQ-010.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  16  IEEE binary16 dividend.
REQ-007 b  input  16  IEEE binary16 divisor.
REQ-008 out_valid  output  1  out holds a completed quotient.
REQ-009 out_ready  input  1  consumer accepts out.
REQ-010 out  output  16  binary16 quotient a/b.

Function
REQ-011 State machine SHALL have four states: IDLE, DIV, ROUND, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 Accept SHALL occur on a cycle where in_valid=1 and in_ready=1 (cycle t); a and b SHALL be registered at that edge and SHALL NOT be sampled again during the operation.
REQ-013 Special-case decode at accept; any input with exponent 0 SHALL be treated as signed zero (subnormal flush).
- NaN operand, 0/0, or inf/inf -> result 16'h7e00.
- inf/finite, or nonzero/0 -> sign_a^sign_b, 5'h1f, 10'h000.
- 0/nonzero, or finite/inf -> sign_a^sign_b, zero.
REQ-014 For a special case the machine SHALL go IDLE->DONE, with out_valid=1 from cycle t+1.
REQ-015 Normal case: ma={1,frac_a}, mb={1,frac_b}; sign SHALL be sign_a^sign_b; e SHALL be a 7-bit signed value equal to exp_a-exp_b+15.
REQ-016 DIV SHALL run exactly 13 cycles (t+1..t+13) of restoring division, one quotient bit per cycle, MSB first, giving q[12:0]=floor(ma*2^12/mb) and remainder rem; the iteration counter SHALL be 4 bits.
REQ-017 ROUND SHALL occupy cycle t+14, and out_valid SHALL be 1 from cycle t+15.
REQ-018 Normalize step.
- If q[12]=1: mant=q[12:2], guard=q[1], sticky=q[0]|(rem!=0), exponent e.
- Else: mant=q[11:1], guard=q[0], sticky=(rem!=0), exponent e-1.
REQ-019 Rounding SHALL be round-to-nearest-even: increment mant when guard & (sticky | mant[0]); a carry to 12'h800 SHALL set mant=11'h400 and add 1 to the exponent.
REQ-020 Final exponent >=31 SHALL produce signed infinity; final exponent <=0 SHALL produce signed zero (no subnormal outputs); otherwise out SHALL be {sign, exp[4:0], mant[9:0]}.
REQ-021 In DONE, out SHALL be held stable until out_valid & out_ready; the machine SHALL then go to IDLE, so in_ready=1 on the next cycle (no same-cycle accept).
REQ-022 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-023 While rst=1 at a clock edge: state<=IDLE, out_valid=0, out=16'h0000, in_ready=1 from the following cycle; the division counter and datapath registers SHALL be cleared.
REQ-024 rst asserted in DIV, ROUND or DONE SHALL abort the operation with no output produced; rst SHALL take priority over every handshake.

Verification
REQ-025 Normal divide: a=3C00, b=4000 accepted at t -> out_valid rises at t+15, out=3800; in_ready=0 over t+1..t+15.
REQ-026 Rounding check: a=3C00, b=4200 -> out=3555 (no round-up); a=4200, b=3C00 -> out=4200.
REQ-027 Overflow: a=7BFF, b=3800 -> out=7C00.
REQ-028 Special cases, each out_valid at t+1:
- 0000/0000 -> 7E00
- 3C00/0000 -> 7C00
- BC00/0000 -> FC00
- 3C00/7C00 -> 0000
- 7E00/3C00 -> 7E00
REQ-029 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle, and a new a=4400, b=4000 yields 4000.
REQ-030 Reset mid-DIV: assert rst at t+6 -> out_valid never rises for that operation, out=0000, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/fp16_divider.sv
// Purpose: IEEE binary16 divider (a/b), restoring division, round-to-nearest-even, subnormals flushed to zero.
// Latency: special operands give out_valid 1 cycle after accept; normal operands 15 cycles after accept.
// Backpressure: single operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module fp16_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state;
  logic               sign;
  logic signed [6:0]  e;
  logic [10:0]        mb;
  logic [11:0]        rem;
  logic [12:0]        q;
  logic [3:0]         cnt;

  // operand field decode
  logic [4:0] ea, eb;
  logic [9:0] fa, fb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic       spec;
  logic [15:0] spec_res;
  logic [6:0] e_in;

  assign ea     = a[14:10];
  assign eb     = b[14:10];
  assign fa     = a[9:0];
  assign fb     = b[9:0];
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'h1f) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1f) && (fb == 10'd0);
  assign a_nan  = (ea == 5'h1f) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1f) && (fb != 10'd0);
  // biased exponent difference; wraps into a 7-bit two's complement value
  assign e_in   = {2'b00, ea} - {2'b00, eb} + 7'd15;

  // special-operand classification and the result it forces
  always_comb begin
    spec     = 1'b1;
    spec_res = 16'h0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_res = 16'h7e00;
    else if (a_inf || b_zero)
      spec_res = {a[15] ^ b[15], 5'h1f, 10'h000};
    else if (a_zero || b_inf)
      spec_res = {a[15] ^ b[15], 15'h0000};
    else
      spec = 1'b0;
  end

  // one restoring-division step: compare, conditionally subtract, shift for the next bit
  logic        ge;
  logic [11:0] rem_next;

  always_comb begin
    ge       = (rem >= {1'b0, mb});
    rem_next = (ge ? (rem - {1'b0, mb}) : rem) << 1;
  end

  // normalize, round to nearest even, then range-check the exponent
  logic [9:0]        frac;
  logic              guard, sticky, inc, carry;
  logic [9:0]        frac_r;
  logic signed [7:0] ex, ex_f;
  logic [15:0]       res;

  always_comb begin
    if (q[12]) begin
      frac   = q[11:2];
      guard  = q[1];
      sticky = q[0] | (rem != 12'd0);
      ex     = {e[6], e};
    end else begin
      frac   = q[10:1];
      guard  = q[0];
      sticky = (rem != 12'd0);
      ex     = {e[6], e} - 8'sd1;
    end
    // hidden bit is always 1 here, so a fraction overflow is exactly a mantissa carry to 2.0
    inc             = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {10'd0, inc};
    ex_f            = ex + {7'd0, carry};
    if (ex_f >= 8'sd31)
      res = {sign, 5'h1f, 10'h000};
    else if (ex_f <= 8'sd0)
      res = {sign, 15'h0000};
    else
      res = {sign, ex_f[4:0], frac_r};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= 16'h0000;
      sign  <= 1'b0;
      e     <= 7'sd0;
      mb    <= 11'd0;
      rem   <= 12'd0;
      q     <= 13'd0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= a[15] ^ b[15];
            e    <= e_in;
            mb   <= {1'b1, fb};
            rem  <= {2'b01, fa};
            q    <= 13'd0;
            cnt  <= 4'd0;
            if (spec) begin
              out   <= spec_res;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= {q[11:0], ge};
          rem <= rem_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd12) state <= ROUND;
        end
        ROUND: begin
          out   <= res;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
